ili9341_spi_peripheral: RTL

Synthesizable model of the ILI9341 panel's SPI write interface: the receiving end of the display controller's 4-wire SPI link (8-bit serial mode, SPI mode 0). It oversamples the bus in the `clk` domain and assembles bytes. Each byte is classified as command or data by `data_commandb`. The block tracks CASET/PASET address windows and emits one RGB565 pixel write per pair of RAMWR data bytes. Its pixel outputs feed a frame buffer or checker, on the FPGA or in the bench, in place of a physical panel.

---
 rtl/ili9341_spi_peripheral.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ili9341_spi_peripheral.sv
// ILI9341 4-wire SPI write-side receiver: oversamples the bus in clk, assembles bytes,
// tracks CASET/PASET windows and emits one RGB565 pixel per RAMWR data byte pair.
module ili9341_spi_peripheral #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                spi_csb,
  input  logic                                spi_clk,
  input  logic                                spi_mosi,
  input  logic                                data_commandb,
  output logic                                spi_miso,
  output logic                                cmd_valid,
  output logic [7:0]                          cmd_byte,
  output logic                                pixel_valid,
  output logic [$clog2(DISPLAY_WIDTH):0]      pixel_x,
  output logic [$clog2(DISPLAY_HEIGHT):0]     pixel_y,
  output logic [15:0]                         pixel_color,
  output logic                                frame_done,
  output logic                                display_on,
  output logic                                sleep_out
);

  localparam int XW = $clog2(DISPLAY_WIDTH) + 1;
  localparam int YW = $clog2(DISPLAY_HEIGHT) + 1;
  localparam logic [15:0]   X_MAX   = 16'(DISPLAY_WIDTH - 1);
  localparam logic [15:0]   Y_MAX   = 16'(DISPLAY_HEIGHT - 1);
  localparam logic [XW-1:0] COL_MAX = XW'(DISPLAY_WIDTH - 1);
  localparam logic [YW-1:0] ROW_MAX = YW'(DISPLAY_HEIGHT - 1);

  typedef enum logic [1:0] {S_IGNORE, S_CASET, S_PASET, S_RAMWR} state_t;

  assign spi_miso = 1'b0;

  // Front end: 2-flop synchronizers plus a third sclk stage for rise detection
  logic [1:0] csb_sync, sclk_sync, mosi_sync, dc_sync;
  logic       sclk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      csb_sync  <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      dc_sync   <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[0], spi_csb};
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      dc_sync   <= {dc_sync[0], data_commandb};
      sclk_d    <= sclk_sync[1];
    end
  end

  logic       sclk_rise;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       byte_done;
  logic [7:0] byte_val;
  logic       byte_dc;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  // Counter only advances under csb low, so bit_cnt==7 implies the byte began under csb low;
  // an edge coinciding with the csb rise still completes it before the clear.
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);
  assign byte_val  = {shreg, mosi_sync[1]};
  assign byte_dc   = dc_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else begin
      if (sclk_rise) begin
        shreg   <= byte_val[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (csb_sync[1]) bit_cnt <= 3'd0;
    end
  end

  // Decoder FSM
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IGNORE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_done && !byte_dc) begin
      case (byte_val)
        8'h2A:   state_nxt = S_CASET;
        8'h2B:   state_nxt = S_PASET;
        8'h2C:   state_nxt = S_RAMWR;
        default: state_nxt = S_IGNORE;
      endcase
    end
  end

  logic [2:0]  data_cnt;
  logic [23:0] param_buf;
  logic [15:0] win_sc, win_ec_raw, win_lim, win_ec;
  logic        win_ok;

  assign win_sc     = param_buf[23:8];
  assign win_ec_raw = {param_buf[7:0], byte_val};
  assign win_lim    = (state == S_PASET) ? Y_MAX : X_MAX;
  assign win_ec     = (win_ec_raw > win_lim) ? win_lim : win_ec_raw;
  assign win_ok     = (win_sc <= win_ec);

  logic is_cmd, data_win, data_ramwr, commit_col, commit_page;

  always_comb begin
    is_cmd      = byte_done & ~byte_dc;
    data_win    = 1'b0;
    data_ramwr  = 1'b0;
    commit_col  = 1'b0;
    commit_page = 1'b0;
    if (byte_done && byte_dc) begin
      case (state)
        S_CASET: begin
          data_win   = 1'b1;
          commit_col = (data_cnt == 3'd3) && win_ok;
        end
        S_PASET: begin
          data_win    = 1'b1;
          commit_page = (data_cnt == 3'd3) && win_ok;
        end
        S_RAMWR: data_ramwr = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: windows, write cursor, registered outputs
  logic [XW-1:0] col_start, col_end, act_col_start, act_col_end, cur_x;
  logic [YW-1:0] page_start, page_end, act_page_start, act_page_end, cur_y;
  logic          half;
  logic [7:0]    color_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid      <= 1'b0;
      cmd_byte       <= 8'h00;
      pixel_valid    <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      pixel_color    <= 16'h0000;
      frame_done     <= 1'b0;
      display_on     <= 1'b0;
      sleep_out      <= 1'b0;
      data_cnt       <= 3'd0;
      param_buf      <= 24'd0;
      col_start      <= '0;
      col_end        <= COL_MAX;
      page_start     <= '0;
      page_end       <= ROW_MAX;
      act_col_start  <= '0;
      act_col_end    <= COL_MAX;
      act_page_start <= '0;
      act_page_end   <= ROW_MAX;
      cur_x          <= '0;
      cur_y          <= '0;
      half           <= 1'b0;
      color_hi       <= 8'h00;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;

      if (is_cmd) begin
        cmd_byte  <= byte_val;
        cmd_valid <= 1'b1;
        data_cnt  <= 3'd0;
        half      <= 1'b0;
        case (byte_val)
          8'h01: begin
            col_start  <= '0;
            col_end    <= COL_MAX;
            page_start <= '0;
            page_end   <= ROW_MAX;
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
          end
          8'h10: sleep_out  <= 1'b0;
          8'h11: sleep_out  <= 1'b1;
          8'h28: display_on <= 1'b0;
          8'h29: display_on <= 1'b1;
          8'h2C: begin
            // Window is frozen for the whole RAMWR burst
            act_col_start  <= col_start;
            act_col_end    <= col_end;
            act_page_start <= page_start;
            act_page_end   <= page_end;
            cur_x          <= col_start;
            cur_y          <= page_start;
          end
          default: ;
        endcase
      end

      if (data_win && data_cnt < 3'd4) begin
        data_cnt  <= data_cnt + 3'd1;
        param_buf <= {param_buf[15:0], byte_val};
      end
      if (commit_col) begin
        col_start <= XW'(win_sc);
        col_end   <= XW'(win_ec);
      end
      if (commit_page) begin
        page_start <= YW'(win_sc);
        page_end   <= YW'(win_ec);
      end

      if (data_ramwr) begin
        if (!half) begin
          color_hi <= byte_val;
          half     <= 1'b1;
        end else begin
          half        <= 1'b0;
          pixel_valid <= 1'b1;
          pixel_x     <= cur_x;
          pixel_y     <= cur_y;
          pixel_color <= {color_hi, byte_val};
          if (cur_x < act_col_end) begin
            cur_x <= cur_x + XW'(1);
          end else begin
            cur_x <= act_col_start;
            if (cur_y < act_page_end) begin
              cur_y <= cur_y + YW'(1);
            end else begin
              cur_y      <= act_page_start;
              frame_done <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
